// File: rtl/ddr_wr_ctrl.sv
// AXI write-burst master: a rising edge on i_mbus_wrq launches one fixed-length
// AXI write burst whose beats come from a first-word-fall-through source.
//
// state | meaning
// IDLE  | waiting for a wrq rising edge
// LATCH | capture burst address, clear beat counter
// AW    | address phase, awvalid high
// W     | data beats, wvalid high
// B     | waiting for write response, bready high
// DONE  | one-cycle completion pulse

module ddr_wr_ctrl #(
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int BURST_LENGTH    = 8,
  parameter int BURST_NUM       = 15,
  parameter int BURST_WIDTH     = 4
) (
  input  logic                                   i_axi_aclk,
  input  logic                                   i_rstn,
  output logic [CTRL_ADDR_WIDTH-1:0]             o_axi_awaddr,
  output logic [BURST_WIDTH-1:0]                 o_axi_awlen,
  output logic                                   o_axi_awvalid,
  input  logic                                   i_axi_awready,
  output logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0]   o_axi_wdata,
  output logic [MEM_DQ_WIDTH*BURST_LENGTH/8-1:0] o_axi_wstrb,
  output logic                                   o_axi_wlast,
  output logic                                   o_axi_wvalid,
  input  logic                                   i_axi_wready,
  input  logic                                   i_axi_bvalid,
  output logic                                   o_axi_bready,
  input  logic                                   i_mbus_wrq,
  input  logic [CTRL_ADDR_WIDTH-1:0]             i_mbus_waddr,
  input  logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0]   i_mbus_wdata,
  output logic                                   o_mbus_wdata_rq,
  output logic                                   o_mbus_wbusy,
  output logic                                   o_mbus_wdone
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 wrq_sr_q, wrq_sr_d;
  logic [BURST_WIDTH-1:0]     beat_cnt_q, beat_cnt_d;
  logic [CTRL_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                       wrq_rise;
  logic                       beat_hs;
  logic                       last_beat;

  always_ff @(posedge i_axi_aclk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      wrq_sr_q   <= 2'b00;
      beat_cnt_q <= '0;
      awaddr_q   <= '0;
    end else begin
      state_q    <= state_d;
      wrq_sr_q   <= wrq_sr_d;
      beat_cnt_q <= beat_cnt_d;
      awaddr_q   <= awaddr_d;
    end
  end

  // Edges seen outside IDLE are dropped, not queued.
  always_comb begin
    wrq_sr_d      = {wrq_sr_q[0], i_mbus_wrq};
    wrq_rise      = (wrq_sr_q == 2'b01);
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    awaddr_d      = awaddr_q;
    o_axi_awvalid = 1'b0;
    o_axi_wvalid  = 1'b0;
    o_axi_bready  = 1'b0;
    o_mbus_wdone  = 1'b0;
    beat_hs       = 1'b0;
    last_beat     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wrq_rise) state_d = S_LATCH;
      end
      S_LATCH: begin
        beat_cnt_d = '0;
        awaddr_d   = i_mbus_waddr;
        state_d    = S_AW;
      end
      S_AW: begin
        o_axi_awvalid = 1'b1;
        if (i_axi_awready) state_d = S_W;
      end
      S_W: begin
        o_axi_wvalid = 1'b1;
        beat_hs      = i_axi_wready;
        last_beat    = (beat_cnt_q == BURST_WIDTH'(BURST_NUM));
        if (beat_hs) begin
          beat_cnt_d = beat_cnt_q + BURST_WIDTH'(1);
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        o_axi_bready = 1'b1;
        if (i_axi_bvalid) state_d = S_DONE;
      end
      S_DONE: begin
        o_mbus_wdone = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_axi_awaddr    = awaddr_q;
  assign o_axi_awlen     = BURST_WIDTH'(BURST_NUM);
  assign o_axi_wstrb     = '1;
  assign o_axi_wdata     = i_mbus_wdata;
  assign o_axi_wlast     = last_beat;
  assign o_mbus_wdata_rq = beat_hs;
  assign o_mbus_wbusy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ddr_wr_ctrl.sv
// Scoreboard bench for ddr_wr_ctrl: bursts are announced into expectation
// queues when requested, and a negedge monitor pops and compares them.

module tb_ddr_wr_ctrl;
  localparam int DQ = 16, AW = 28, BL = 8, BN = 15, BW = 4;
  localparam int DW = DQ * BL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rstn, i_axi_awready, i_axi_wready, i_axi_bvalid, i_mbus_wrq;
  logic [AW-1:0] i_mbus_waddr;
  logic [DW-1:0] i_mbus_wdata;
  logic [AW-1:0] o_axi_awaddr;
  logic [BW-1:0] o_axi_awlen;
  logic [DW-1:0] o_axi_wdata;
  logic [DW/8-1:0] o_axi_wstrb;
  logic o_axi_awvalid, o_axi_wlast, o_axi_wvalid, o_axi_bready;
  logic o_mbus_wdata_rq, o_mbus_wbusy, o_mbus_wdone;

  ddr_wr_ctrl #(.MEM_DQ_WIDTH(DQ), .CTRL_ADDR_WIDTH(AW), .BURST_LENGTH(BL),
                .BURST_NUM(BN), .BURST_WIDTH(BW)) dut (
    .i_axi_aclk(clk), .i_rstn(i_rstn),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awlen(o_axi_awlen),
    .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wlast(o_axi_wlast),
    .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
    .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
    .i_mbus_wrq(i_mbus_wrq), .i_mbus_waddr(i_mbus_waddr), .i_mbus_wdata(i_mbus_wdata),
    .o_mbus_wdata_rq(o_mbus_wdata_rq), .o_mbus_wbusy(o_mbus_wbusy),
    .o_mbus_wdone(o_mbus_wdone)
  );

  typedef struct {int idx; bit last;} beat_t;

  int total = 0, bad = 0;
  beat_t beat_q[$];
  logic [AW-1:0] aw_q[$];
  int done_q[$];
  int src_idx = 0, model_next = 0, mode = 0;
  int beats_seen = 0, aw_cyc = 0, busy_run = 0, aw_total = 0, aw_exp_total = 0;
  bit hs_neg = 1'b0, hold_pend = 1'b0;
  logic [DW-1:0] held;

  function automatic logic [DW-1:0] word(int n);
    logic [31:0] u;
    u = n;
    return {u ^ 32'hA5A5_0000, ~u, u * 32'd3, 32'hDEAD_0000 + u};
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: every accepted request yields one address, BN+1 consecutive
  // source words with last on the final one, and one done pulse.
  task automatic expect_burst(logic [AW-1:0] a);
    beat_t b;
    aw_q.push_back(a);
    aw_exp_total++;
    for (int i = 0; i <= BN; i++) begin
      b.idx  = model_next + i;
      b.last = (i == BN);
      beat_q.push_back(b);
    end
    model_next += BN + 1;
    done_q.push_back(1);
  endtask

  task automatic pulse(logic [AW-1:0] a, bit acc);
    @(posedge clk); #1;
    i_mbus_waddr = a;
    i_mbus_wrq   = 1'b1;
    if (acc) expect_burst(a);
    repeat (2) @(posedge clk);
    #1 i_mbus_wrq = 1'b0;
  endtask

  task automatic wait_idle(string nm, int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((done_q.size() != 0 || o_mbus_wbusy) && n < budget);
    chk({nm, "_timeout"}, n < budget, 1);
  endtask

  task automatic check_zero(string nm);
    chk({nm, "_awvalid"}, o_axi_awvalid, 0);
    chk({nm, "_wvalid"}, o_axi_wvalid, 0);
    chk({nm, "_wlast"}, o_axi_wlast, 0);
    chk({nm, "_bready"}, o_axi_bready, 0);
    chk({nm, "_rq"}, o_mbus_wdata_rq, 0);
    chk({nm, "_busy"}, o_mbus_wbusy, 0);
    chk({nm, "_done"}, o_mbus_wdone, 0);
    chk({nm, "_awaddr"}, o_axi_awaddr, 0);
  endtask

  // Slave and FWFT source driver.
  initial begin : drv
    bit tog = 1'b0;
    int awc = 0, bc = 0;
    i_axi_awready = 1'b0;
    i_axi_wready  = 1'b0;
    i_axi_bvalid  = 1'b0;
    i_mbus_wdata  = word(0);
    forever begin
      @(posedge clk); #1;
      if (hs_neg) src_idx++;
      i_mbus_wdata = word(src_idx);
      tog = ~tog;
      awc = o_axi_awvalid ? awc + 1 : 0;
      bc  = o_axi_bready ? bc + 1 : 0;
      case (mode)
        0: begin
          i_axi_awready = 1'b1; i_axi_wready = 1'b1; i_axi_bvalid = 1'b1;
        end
        1: begin
          i_axi_awready = 1'($urandom_range(0, 1));
          i_axi_wready  = 1'($urandom_range(0, 1));
          i_axi_bvalid  = 1'($urandom_range(0, 1));
        end
        default: begin
          i_axi_awready = (awc >= 6);
          i_axi_wready  = tog;
          i_axi_bvalid  = (bc >= 4);
        end
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin : mon
    beat_t b;
    forever begin
      @(negedge clk);
      hs_neg = o_mbus_wdata_rq;
      chk("exclusive_valids", $countones({o_axi_awvalid, o_axi_wvalid, o_axi_bready}) <= 1, 1);
      chk("rq_eq_hs", o_mbus_wdata_rq, o_axi_wvalid & i_axi_wready);
      if (hold_pend && o_axi_wvalid) chk("wdata_hold", o_axi_wdata, held);
      hold_pend = 1'b0;
      if (o_axi_wvalid && !i_axi_wready) begin
        held = o_axi_wdata;
        hold_pend = 1'b1;
      end
      if (o_axi_awvalid) aw_cyc++;
      if (o_axi_awvalid && i_axi_awready) begin
        aw_total++;
        chk("aw_expected", aw_q.size() > 0, 1);
        if (aw_q.size() > 0) chk("awaddr", o_axi_awaddr, aw_q.pop_front());
        chk("awlen", o_axi_awlen, BN);
        chk("wstrb", o_axi_wstrb, {(DW/8){1'b1}});
        if (mode == 2) chk("aw_hold_cycles", aw_cyc, 6);
        aw_cyc = 0;
      end else if (!o_axi_awvalid) begin
        aw_cyc = 0;
      end
      if (o_axi_wvalid && i_axi_wready) begin
        chk("beat_expected", beat_q.size() > 0, 1);
        if (beat_q.size() > 0) begin
          b = beat_q.pop_front();
          chk("wdata", o_axi_wdata, word(b.idx));
          chk("wlast", o_axi_wlast, b.last);
          beats_seen = b.last ? 0 : beats_seen + 1;
        end
      end
      busy_run = o_mbus_wbusy ? busy_run + 1 : 0;
      if (o_mbus_wdone) begin
        chk("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) void'(done_q.pop_front());
        if (mode == 0) chk("busy_len", busy_run, 20);
      end
    end
  end

  initial begin : main
    int n;
    i_rstn = 1'b0;
    i_mbus_wrq = 1'b0;
    i_mbus_waddr = '0;
    repeat (3) @(posedge clk);
    #1 i_rstn = 1'b1;
    @(negedge clk); #1;
    check_zero("reset");

    // basic zero-wait burst with latency check
    mode = 0;
    @(posedge clk); #1;
    i_mbus_waddr = 28'h0001000;
    i_mbus_wrq = 1'b1;
    expect_burst(28'h0001000);
    n = 0;
    while (!o_axi_awvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("aw_latency", n, 4);
    @(posedge clk); #1 i_mbus_wrq = 1'b0;
    wait_idle("basic", 100);

    // backpressure
    mode = 2;
    pulse(28'h0003400, 1'b1);
    wait_idle("backpressure", 300);

    // second edge while busy is ignored
    mode = 1;
    pulse(28'h0004000, 1'b1);
    n = 0;
    while (!o_axi_wvalid && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reach_w", o_axi_wvalid, 1);
    pulse(28'h0005000, 1'b0);
    wait_idle("busy_ignore", 400);

    // back-to-back
    mode = 0;
    pulse(28'h0001000, 1'b1);
    n = 0;
    while (!o_mbus_wdone && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("b2b_first_done", o_mbus_wdone, 1);
    pulse(28'h0002000, 1'b1);
    wait_idle("b2b", 100);

    // reset in the middle of the data phase, right after beat 7
    pulse(28'h0006000, 1'b1);
    n = 0;
    while (beats_seen != 7 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reach_beat7", beats_seen, 7);
    i_rstn = 1'b0;
    @(posedge clk); #1 i_rstn = 1'b1;
    @(negedge clk); #1;
    check_zero("abort");
    beat_q.delete();
    aw_q.delete();
    done_q.delete();
    beats_seen = 0;
    model_next = src_idx;
    repeat (5) @(posedge clk);
    pulse(28'h0007000, 1'b1);
    wait_idle("after_abort", 100);

    // request level held through reset release: exactly one burst
    @(posedge clk); #1;
    i_rstn = 1'b0;
    i_mbus_waddr = 28'h0008000;
    i_mbus_wrq = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_rstn = 1'b1;
    expect_burst(28'h0008000);
    wait_idle("level", 100);
    repeat (40) @(posedge clk);
    #1 i_mbus_wrq = 1'b0;
    pulse(28'h0009000, 1'b1);
    wait_idle("level_rerise", 100);

    // randomized readies and addresses
    for (int i = 0; i < 6; i++) begin
      mode = (i % 3 == 0) ? 0 : 1;
      pulse(AW'($urandom), 1'b1);
      wait_idle("random", 400);
    end

    chk("aw_count", aw_total, aw_exp_total);
    chk("queues_drained", beat_q.size() + aw_q.size() + done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
